// File: rtl/clk_set_ctrl_if.sv
// Button and strobe bundle between the front panel and the time-set
// sequencer. The sequencer is the slave: it reads the raw active-low
// buttons and drives the count tick, increment strobes and set-mode level.
interface clk_set_ctrl_if;
  logic set_n;     // raw set button, 0 = pressed
  logic hour_n;    // raw hour button, 0 = pressed
  logic minute_n;  // raw minute button, 0 = pressed
  logic tick;      // one-cycle seconds count enable
  logic inc_hour;  // one-cycle hour-increment strobe
  logic inc_min;   // one-cycle minute-increment strobe
  logic set_mode;  // high while the debounced set button is held

  modport master (
    output set_n, hour_n, minute_n,
    input  tick, inc_hour, inc_min, set_mode
  );

  modport slave (
    input  set_n, hour_n, minute_n,
    output tick, inc_hour, inc_min, set_mode
  );
endinterface

// File: rtl/clk_set_ctrl.sv
// Time-set sequencer in front of the 12-hour time counter.
// Raw buttons are synchronised and debounced; a prescaler produces the
// seconds tick while running, and a small FSM turns debounced hour/minute
// presses into one-cycle increment strobes with press-and-hold auto-repeat.
// Wrapping of hours/minutes lives in the time counter, not here.
module clk_set_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DEB_CYC   = 1_000_000,
  parameter int unsigned RPT_FIRST = 25_000_000,
  parameter int unsigned RPT_RATE  = 5_000_000
) (
  input  logic          clk,
  input  logic          reset,
  clk_set_ctrl_if.slave bus
);

  // Debounce counter only needs to reach DEB_CYC-1.
  localparam int unsigned       DEB_W          = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST       = DEB_W'(DEB_CYC - 1);
  localparam logic [31:0]       TICK_LAST      = 32'(TICK_DIV - 1);
  localparam logic [31:0]       RPT_FIRST_LAST = 32'(RPT_FIRST - 1);
  localparam logic [31:0]       RPT_RATE_LAST  = 32'(RPT_RATE - 1);

  // Bit positions of the three buttons in the conditioning vectors.
  localparam int BTN_SET  = 0;
  localparam int BTN_HOUR = 1;
  localparam int BTN_MIN  = 2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_IDLE,
    ST_HOLD_H,
    ST_HOLD_M
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [2:0]            raw_n;
  logic [2:0]            sync1_q;
  logic [2:0]            sync2_q;
  logic [2:0]            pressed;     // synchronised, 1 = pressed
  logic [2:0][DEB_W-1:0] deb_cnt_q;
  logic [2:0][DEB_W-1:0] deb_cnt_d;
  logic [2:0]            deb_lvl_q;   // debounced level, 1 = pressed
  logic [2:0]            deb_lvl_d;
  logic [2:0]            deb_rise_q;  // one cycle after a debounced press edge
  logic [2:0]            deb_rise_d;

  assign raw_n   = {bus.minute_n, bus.hour_n, bus.set_n};
  assign pressed = ~sync2_q;

  // Two-flop synchroniser; resets to the released (high) level.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from the previous cycle's values; with
  // blocking assignments sync2_q would catch the raw input in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: flip only after DEB_CYC consecutive differing samples.
  // NOTE: each loop iteration assigns all three _d signals before any
  // condition, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      deb_cnt_d[b]  = '0;
      deb_lvl_d[b]  = deb_lvl_q[b];
      deb_rise_d[b] = 1'b0;
      if (pressed[b] != deb_lvl_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) begin
          // Accepted change; the counter restarts for the next one.
          deb_lvl_d[b]  = pressed[b];
          deb_rise_d[b] = pressed[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
        end
      end
      // A sample that agrees with the current level leaves the count at 0,
      // so any bounce restarts the qualification window.
    end
  end

  // Debounce state registers; buttons read released out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_q  <= '0;
      deb_lvl_q  <= '0;
      deb_rise_q <= '0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_rise_q <= deb_rise_d;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM, prescaler and auto-repeat
  // ---------------------------------------------------------------------
  state_t      state_q;
  logic [31:0] presc_q;
  logic [31:0] rpt_q;
  logic        rpt_first_q;  // waiting for the first (long) repeat interval
  logic        tick_q;
  logic        inc_hour_q;
  logic        inc_min_q;
  logic        set_mode_q;

  logic set_lvl;
  logic hour_rise;
  logic min_rise;
  logic hold_lvl;
  logic rpt_due;

  assign set_lvl   = deb_lvl_q[BTN_SET];
  assign hour_rise = deb_rise_q[BTN_HOUR];
  assign min_rise  = deb_rise_q[BTN_MIN];
  // Level of whichever key owns the current hold state.
  assign hold_lvl  = (state_q == ST_HOLD_H) ? deb_lvl_q[BTN_HOUR] : deb_lvl_q[BTN_MIN];
  assign rpt_due   = rpt_first_q ? (rpt_q == RPT_FIRST_LAST) : (rpt_q == RPT_RATE_LAST);

  // Mode sequencing with registered tick, strobes and set-mode level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
      tick_q      <= 1'b0;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      set_mode_q  <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      tick_q     <= 1'b0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;

      case (state_q)
        ST_RUN: begin
          if (set_lvl) begin
            state_q    <= ST_SET_IDLE;
            set_mode_q <= 1'b1;
            presc_q    <= '0;
          end else if (presc_q == TICK_LAST) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + 32'd1;
          end
        end

        ST_SET_IDLE: begin
          // Prescaler is held at 0 outside RUN, so the first tick after
          // returning to RUN comes a full TICK_DIV cycles later.
          presc_q <= '0;
          if (!set_lvl) begin
            state_q    <= ST_RUN;
            set_mode_q <= 1'b0;
          end else if (hour_rise) begin
            // Hour wins a same-cycle tie; the minute edge is dropped.
            state_q     <= ST_HOLD_H;
            inc_hour_q  <= 1'b1;
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
          end else if (min_rise) begin
            state_q     <= ST_HOLD_M;
            inc_min_q   <= 1'b1;
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
          end
        end

        ST_HOLD_H, ST_HOLD_M: begin
          presc_q <= '0;
          if (!set_lvl) begin
            // Leaving set mode cancels any pending repeat.
            state_q    <= ST_RUN;
            set_mode_q <= 1'b0;
            rpt_q      <= '0;
          end else if (!hold_lvl) begin
            // Any other key still held produces nothing until re-pressed,
            // because only a debounced press edge starts a strobe.
            state_q <= ST_SET_IDLE;
            rpt_q   <= '0;
          end else if (rpt_due) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
            if (state_q == ST_HOLD_H) begin
              inc_hour_q <= 1'b1;
            end else begin
              inc_min_q <= 1'b1;
            end
          end else begin
            rpt_q <= rpt_q + 32'd1;
          end
        end

        default: begin
          state_q    <= ST_RUN;
          set_mode_q <= 1'b0;
          presc_q    <= '0;
        end
      endcase
    end
  end

  assign bus.tick     = tick_q;
  assign bus.inc_hour = inc_hour_q;
  assign bus.inc_min  = inc_min_q;
  assign bus.set_mode = set_mode_q;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Bench for clk_set_ctrl with short timing parameters. Expected tick and
// strobe cycles are pushed to a scoreboard when stimulus is applied and
// matched as the DUT emits pulses; a vector table covers bounce rejection
// and RUN/SET transitions by counting pulses per segment.
module tb_clk_set_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int DEB_CYC   = 4;
  localparam int RPT_FIRST = 20;
  localparam int RPT_RATE  = 5;

  // Raw press to strobe latency: 2 sync + DEB_CYC debounce + 1 register.
  localparam int LAT = 2 + DEB_CYC + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  clk_set_ctrl_if bus ();

  clk_set_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYC   (DEB_CYC),
    .RPT_FIRST (RPT_FIRST),
    .RPT_RATE  (RPT_RATE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef enum int {EV_TICK, EV_HOUR, EV_MIN} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  ev_t sb_q[$];
  int  cyc = 0;
  bit  sb_on = 1'b1;
  bit  ign_tick = 1'b0;
  int  n_tick = 0;
  int  n_hour = 0;
  int  n_min = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input ev_kind_t k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic sb_match(input ev_kind_t k, input string name);
    int idx;
    idx = -1;
    for (int i = 0; i < sb_q.size(); i++)
      if (sb_q[i].kind == k && sb_q[i].cyc == cyc) idx = i;
    check($sformatf("%s_expected_at_cycle_%0d", name, cyc), (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) sb_q.delete(idx);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < sb_q.size(); i++)
      $display("  missing pulse kind=%0d cycle=%0d (%s)", sb_q[i].kind, sb_q[i].cyc, name);
    check({name, "_missed_pulses"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tick) begin
        n_tick <= n_tick + 1;
        if (sb_on && !ign_tick) sb_match(EV_TICK, "tick");
      end
      if (bus.inc_hour) begin
        n_hour <= n_hour + 1;
        if (sb_on) sb_match(EV_HOUR, "inc_hour");
      end
      if (bus.inc_min) begin
        n_min <= n_min + 1;
        if (sb_on) sb_match(EV_MIN, "inc_min");
      end
      if (bus.tick || bus.inc_hour || bus.inc_min) begin
        check("hour_min_exclusive", bus.inc_hour & bus.inc_min, 0);
        check("strobe_tick_exclusive", bus.tick & (bus.inc_hour | bus.inc_min), 0);
      end
    end
  end

  // Advance n falling edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Vector table: one segment of constant inputs with expected pulse counts
  // ---------------------------------------------------------------------
  typedef struct {
    logic set_n;
    logic hour_n;
    logic minute_n;
    int   cycles;
    int   exp_tick;
    int   exp_hour;
    int   exp_min;
    logic exp_mode;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic h, input logic m, input int c,
                         input int et, input int eh, input int em, input logic md);
    vec_t v;
    v.set_n = s; v.hour_n = h; v.minute_n = m; v.cycles = c;
    v.exp_tick = et; v.exp_hour = eh; v.exp_min = em; v.exp_mode = md;
    vecs.push_back(v);
  endtask

  // Watchdog: every phase is a fixed number of cycles, this only guards a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int r0, c0, h0, m0, b0, b2, t_s, t_h, t_m;

  initial begin
    bus.set_n    = 1'b1;
    bus.hour_n   = 1'b1;
    bus.minute_n = 1'b1;

    // 1: reset, free run, ticks at exactly 10, 20, 30.
    step(3);
    check("reset_tick", bus.tick, 0);
    check("reset_inc_hour", bus.inc_hour, 0);
    check("reset_inc_min", bus.inc_min, 0);
    check("reset_set_mode", bus.set_mode, 0);
    reset = 1'b0;
    r0 = cyc;
    ign_tick = 1'b0;
    push(EV_TICK, r0 + TICK_DIV);
    push(EV_TICK, r0 + 2 * TICK_DIV);
    push(EV_TICK, r0 + 3 * TICK_DIV);
    step(35);
    drain("t1_run");

    // 2: enter set mode, one short hour press.
    ign_tick = 1'b1;
    c0 = cyc;
    bus.set_n = 1'b0;
    step(LAT - 1);
    check("t2_set_mode_before_latency", bus.set_mode, 0);
    step(1);
    check("t2_set_mode_at_latency", bus.set_mode, 1);
    ign_tick = 1'b0;
    step(3);
    h0 = cyc;
    bus.hour_n = 1'b0;
    push(EV_HOUR, h0 + LAT);
    step(8);
    bus.hour_n = 1'b1;
    step(20);
    drain("t2_hour_press");
    check("t2_set_mode_held", bus.set_mode, 1);

    // 3: minute held 40 cycles, first strobe then auto-repeat.
    m0 = cyc;
    bus.minute_n = 1'b0;
    push(EV_MIN, m0 + LAT);
    push(EV_MIN, m0 + LAT + RPT_FIRST);
    push(EV_MIN, m0 + LAT + RPT_FIRST + RPT_RATE);
    push(EV_MIN, m0 + LAT + RPT_FIRST + 2 * RPT_RATE);
    push(EV_MIN, m0 + LAT + RPT_FIRST + 3 * RPT_RATE);
    step(40);
    bus.minute_n = 1'b1;
    step(15);
    drain("t3_minute_repeat");

    // 4: simultaneous press, hour wins; held minute needs a fresh press.
    b0 = cyc;
    bus.hour_n   = 1'b0;
    bus.minute_n = 1'b0;
    push(EV_HOUR, b0 + LAT);
    step(12);
    bus.hour_n = 1'b1;
    step(15);
    drain("t4_hour_wins");
    bus.minute_n = 1'b1;
    step(10);
    b2 = cyc;
    bus.minute_n = 1'b0;
    push(EV_MIN, b2 + LAT);
    step(10);
    bus.minute_n = 1'b1;
    step(12);
    drain("t4_minute_repress");

    // 5: vector table starting in SET_IDLE with all keys released.
    for (int i = 0; i < 10; i++)
      add_vec(1'b0, (i % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 2, 0, 0, 0, 1'b1);  // hour bounce
    add_vec(1'b0, 1'b1, 1'b1, 10, 0, 0, 0, 1'b1);  // settle after bounce
    add_vec(1'b0, 1'b1, 1'b0, 10, 0, 0, 1, 1'b1);  // minute press
    add_vec(1'b0, 1'b1, 1'b1, 10, 0, 0, 0, 1'b1);  // minute release
    add_vec(1'b1, 1'b1, 1'b1, 12, 0, 0, 0, 1'b0);  // leave set mode
    add_vec(1'b1, 1'b1, 1'b1, 20, 2, 0, 0, 1'b0);  // running: ticks 10 apart
    add_vec(1'b1, 1'b0, 1'b1, 10, 1, 0, 0, 1'b0);  // hour press in RUN ignored
    add_vec(1'b0, 1'b0, 1'b1, 10, 1, 0, 0, 1'b1);  // enter set with hour held
    add_vec(1'b0, 1'b1, 1'b1, 10, 0, 0, 0, 1'b1);  // release hour
    add_vec(1'b0, 1'b0, 1'b1, 8,  0, 1, 0, 1'b1);  // fresh hour press
    add_vec(1'b0, 1'b1, 1'b1, 10, 0, 0, 0, 1'b1);  // release

    sb_on = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.set_n    = vecs[i].set_n;
      bus.hour_n   = vecs[i].hour_n;
      bus.minute_n = vecs[i].minute_n;
      t_s = n_tick;
      t_h = n_hour;
      t_m = n_min;
      step(vecs[i].cycles);
      check($sformatf("vec%0d_tick", i), n_tick - t_s, vecs[i].exp_tick);
      check($sformatf("vec%0d_inc_hour", i), n_hour - t_h, vecs[i].exp_hour);
      check($sformatf("vec%0d_inc_min", i), n_min - t_m, vecs[i].exp_min);
      check($sformatf("vec%0d_set_mode", i), bus.set_mode, vecs[i].exp_mode);
    end
    sb_on = 1'b1;

    // 6: reset while holding hour in HOLD_H; no strobe after reset release.
    h0 = cyc;
    bus.hour_n = 1'b0;
    push(EV_HOUR, h0 + LAT);
    step(10);
    drain("t6_enter_hold");
    reset = 1'b1;
    bus.set_n = 1'b1;
    step(1);
    check("t6_reset_tick", bus.tick, 0);
    check("t6_reset_inc_hour", bus.inc_hour, 0);
    check("t6_reset_inc_min", bus.inc_min, 0);
    check("t6_reset_set_mode", bus.set_mode, 0);
    step(2);
    reset = 1'b0;
    r0 = cyc;
    push(EV_TICK, r0 + TICK_DIV);
    push(EV_TICK, r0 + 2 * TICK_DIV);
    step(25);
    drain("t6_after_reset");
    check("t6_set_mode_run", bus.set_mode, 0);
    bus.hour_n = 1'b1;
    ign_tick = 1'b1;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
